// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: watches ball and paddle geometry, issues bounce commands
// to the ball block, keeps scores, times the serve and detects game over.
module pong_game_ctrl #(
  parameter int SCREEN_X    = 640,
  parameter int SCREEN_Y    = 480,
  parameter int PAD_W       = 10,
  parameter int PAD_H       = 60,
  parameter int LPAD_X      = 20,
  parameter int RPAD_X      = 610,
  parameter int SERVE_DELAY = 25000000,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_w,
  input  logic [7:0] ball_h,
  input  logic [9:0] lpad_y,
  input  logic [9:0] rpad_y,
  output logic [1:0] bounce,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       serving,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    HOLD  = 3'd3,
    SCORE = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam logic [1:0] B_NONE   = 2'b00;
  localparam logic [1:0] B_PADDLE = 2'b01;
  localparam logic [1:0] B_WALL   = 2'b10;
  localparam logic [1:0] B_SERVE  = 2'b11;

  // A ball past the screen edge is a miss even if the paddle sits further out.
  localparam int RMISS = (RPAD_X + PAD_W < SCREEN_X) ? (RPAD_X + PAD_W) : SCREEN_X;

  localparam logic [10:0] C_LPAD_X  = 11'(LPAD_X);
  localparam logic [10:0] C_LPAD_R  = 11'(LPAD_X + PAD_W);
  localparam logic [10:0] C_RPAD_X  = 11'(RPAD_X);
  localparam logic [10:0] C_RPAD_R  = 11'(RPAD_X + PAD_W);
  localparam logic [10:0] C_RMISS   = 11'(RMISS);
  localparam logic [10:0] C_PAD_H   = 11'(PAD_H);
  localparam logic [10:0] C_SCR_Y   = 11'(SCREEN_Y);
  localparam logic [24:0] C_SRV_END = 25'(SERVE_DELAY - 1);
  localparam logic [3:0]  C_WIN     = 4'(WIN_SCORE);

  state_t      r_state;
  logic [1:0]  r_bounce;
  logic [3:0]  r_score_l;
  logic [3:0]  r_score_r;
  logic        r_game_over;
  logic        r_serving;
  logic [24:0] r_cnt;
  logic [9:0]  r_prev_x;
  logic [9:0]  r_prev_y;
  logic        r_dir_r;
  logic        r_dir_d;

  logic        w_step;
  logic [10:0] w_bx_r;
  logic [10:0] w_by_b;
  logic [10:0] w_lpad_b;
  logic [10:0] w_rpad_b;
  logic        w_yov_l;
  logic        w_yov_r;
  logic        w_miss_l;
  logic        w_miss_r;
  logic        w_hit_l;
  logic        w_hit_r;
  logic        w_wall;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  assign w_step   = (ball_x != r_prev_x) || (ball_y != r_prev_y);
  assign w_bx_r   = {1'b0, ball_x} + {3'b000, ball_w};
  assign w_by_b   = {1'b0, ball_y} + {3'b000, ball_h};
  assign w_lpad_b = {1'b0, lpad_y} + C_PAD_H;
  assign w_rpad_b = {1'b0, rpad_y} + C_PAD_H;

  assign w_yov_l  = (w_by_b > {1'b0, lpad_y}) && ({1'b0, ball_y} < w_lpad_b);
  assign w_yov_r  = (w_by_b > {1'b0, rpad_y}) && ({1'b0, ball_y} < w_rpad_b);
  assign w_miss_l = !r_dir_r && ({1'b0, ball_x} < C_LPAD_X);
  assign w_miss_r = r_dir_r && (w_bx_r > C_RMISS);
  assign w_hit_l  = !r_dir_r && ({1'b0, ball_x} <= C_LPAD_R) &&
                    ({1'b0, ball_x} >= C_LPAD_X) && w_yov_l;
  assign w_hit_r  = r_dir_r && (w_bx_r >= C_RPAD_X) && (w_bx_r <= C_RPAD_R) && w_yov_r;
  assign w_wall   = (!r_dir_d && (ball_y == 10'd0)) || (r_dir_d && (w_by_b >= C_SCR_Y));

  // Outputs are all registered; bounce changes one cycle after the event.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bounce    <= B_SERVE;
      r_score_l   <= 4'd0;
      r_score_r   <= 4'd0;
      r_game_over <= 1'b0;
      r_serving   <= 1'b1;
      r_cnt       <= 25'd0;
      r_prev_x    <= ball_x;
      r_prev_y    <= ball_y;
      r_dir_r     <= 1'b1;
      r_dir_d     <= 1'b1;
    end else begin
      r_prev_x <= ball_x;
      r_prev_y <= ball_y;

      if ((r_state == PLAY || r_state == HOLD) && w_step) begin
        if (ball_x != r_prev_x) r_dir_r <= (ball_x > r_prev_x);
        if (ball_y != r_prev_y) r_dir_d <= (ball_y > r_prev_y);
      end

      case (r_state)
        IDLE, OVER: begin
          r_bounce <= B_SERVE;
          if (start) begin
            r_score_l   <= 4'd0;
            r_score_r   <= 4'd0;
            r_game_over <= 1'b0;
            r_serving   <= 1'b1;
            r_cnt       <= 25'd0;
            r_state     <= SERVE;
          end
        end
        SERVE: begin
          r_bounce <= B_SERVE;
          if (r_cnt == C_SRV_END) begin
            r_cnt     <= 25'd0;
            r_dir_r   <= 1'b1;
            r_dir_d   <= 1'b1;
            r_bounce  <= B_NONE;
            r_serving <= 1'b0;
            r_state   <= PLAY;
          end else begin
            r_cnt <= r_cnt + 25'd1;
          end
        end
        PLAY: begin
          if (w_miss_l) begin
            r_score_r <= sat_inc(r_score_r);
            r_bounce  <= B_SERVE;
            r_state   <= SCORE;
          end else if (w_miss_r) begin
            r_score_l <= sat_inc(r_score_l);
            r_bounce  <= B_SERVE;
            r_state   <= SCORE;
          end else if (w_hit_l || w_hit_r) begin
            r_bounce <= B_PADDLE;
            r_state  <= HOLD;
          end else if (w_wall) begin
            r_bounce <= B_WALL;
            r_state  <= HOLD;
          end else begin
            r_bounce <= B_NONE;
          end
        end
        HOLD: begin
          // The ball block only samples on its move tick, so hold until it moves.
          if (w_step) begin
            r_bounce <= B_NONE;
            r_state  <= PLAY;
          end
        end
        SCORE: begin
          r_bounce <= B_SERVE;
          if (w_step) begin
            if (r_score_l == C_WIN || r_score_r == C_WIN) begin
              r_game_over <= 1'b1;
              r_state     <= OVER;
            end else begin
              r_serving <= 1'b1;
              r_cnt     <= 25'd0;
              r_state   <= SERVE;
            end
          end
        end
        default: begin
          r_bounce  <= B_SERVE;
          r_serving <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bounce    = r_bounce;
  assign score_l   = r_score_l;
  assign score_r   = r_score_r;
  assign game_over = r_game_over;
  assign serving   = r_serving;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: serve timing, wall/paddle bounces,
// corner priority, misses and scoring, game over, restart and reset in HOLD.
module tb_pong_game_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_SCORE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  logic       clock;
  logic       reset;
  logic       start;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] ball_w;
  logic [7:0] ball_h;
  logic [9:0] lpad_y;
  logic [9:0] rpad_y;
  logic [1:0] bounce;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       serving;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  pong_game_ctrl #(.SERVE_DELAY(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .ball_w   (ball_w),
    .ball_h   (ball_h),
    .lpad_y   (lpad_y),
    .rpad_y   (rpad_y),
    .bounce   (bounce),
    .score_l  (score_l),
    .score_r  (score_r),
    .game_over(game_over),
    .serving  (serving),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver: advance one edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sb(input string tag, input logic [2:0] st, input logic [1:0] bnc);
    check({tag, "_state"}, 32'(dbg_state), 32'(st));
    check({tag, "_bounce"}, 32'(bounce), 32'(bnc));
  endtask

  // Right player misses from centre; ends in PLAY after serve, or in OVER.
  task automatic miss_r_round(input logic [3:0] exp_l, input logic [3:0] exp_r, input bit last);
    ball_x = 10'd300; ball_y = 10'd200; tick();
    ball_x = 10'd400; tick();
    ball_x = 10'd630; tick();
    check_sb("missr_score", S_SCORE, 2'b11);
    check("missr_score_l", 32'(score_l), 32'(exp_l));
    ball_x = 10'd315; tick();
    if (!last) begin
      check_sb("missr_reserve", S_SERVE, 2'b11);
      for (int i = 0; i < 8; i++) tick();
      check_sb("missr_play", S_PLAY, 2'b00);
    end else begin
      check_sb("missr_over", S_OVER, 2'b11);
      check("over_game_over", 32'(game_over), 32'd1);
      check("over_score_l", 32'(score_l), 32'(exp_l));
      check("over_score_r", 32'(score_r), 32'(exp_r));
      check("over_serving", 32'(serving), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    ball_x = 10'd300; ball_y = 10'd200; ball_w = 8'd10; ball_h = 8'd15;
    lpad_y = 10'd300; rpad_y = 10'd300;
    tick(); tick();
    check_sb("reset", S_IDLE, 2'b11);
    check("reset_score_l", 32'(score_l), 32'd0);
    check("reset_score_r", 32'(score_r), 32'd0);
    check("reset_game_over", 32'(game_over), 32'd0);
    check("reset_serving", 32'(serving), 32'd1);

    reset = 1'b0; tick();
    check_sb("idle_wait", S_IDLE, 2'b11);

    // Serve: 8 cycles of 11, then 00 with serving falling on the same edge
    start = 1'b1; tick(); start = 1'b0;
    check_sb("serve_enter", S_SERVE, 2'b11);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_sb("serve_hold", S_SERVE, 2'b11);
      check("serve_serving", 32'(serving), 32'd1);
    end
    tick();
    check_sb("serve_done", S_PLAY, 2'b00);
    check("play_serving", 32'(serving), 32'd0);

    // Top wall: ball moving up reaches row 0
    ball_y = 10'd190; tick();
    check_sb("up_step", S_PLAY, 2'b00);
    ball_y = 10'd0; tick();
    check_sb("wall_top", S_HOLD, 2'b10);
    tick();
    check_sb("wall_hold", S_HOLD, 2'b10);
    ball_y = 10'd1; tick();
    check_sb("wall_release", S_PLAY, 2'b00);

    // Left paddle: out of reach first, then overlapping
    ball_x = 10'd290; ball_y = 10'd200; tick();
    ball_x = 10'd30; tick();
    check_sb("lpad_no_overlap", S_PLAY, 2'b00);
    lpad_y = 10'd180; tick();
    check_sb("lpad_hit", S_HOLD, 2'b01);
    tick();
    check_sb("lpad_hold", S_HOLD, 2'b01);
    ball_x = 10'd31; tick();
    check_sb("lpad_release", S_PLAY, 2'b00);

    // Left miss at column 19
    ball_x = 10'd25; tick();
    lpad_y = 10'd300; ball_x = 10'd19; tick();
    check_sb("missl", S_SCORE, 2'b11);
    check("missl_score_r", 32'(score_r), 32'd1);
    check("missl_score_l", 32'(score_l), 32'd0);
    tick();
    check_sb("missl_wait", S_SCORE, 2'b11);
    ball_x = 10'd315; ball_y = 10'd232; tick();
    check_sb("missl_reserve", S_SERVE, 2'b11);
    check("missl_serving", 32'(serving), 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check_sb("missl_play", S_PLAY, 2'b00);

    // Corner: top wall and left paddle together, paddle first
    ball_x = 10'd100; ball_y = 10'd100; lpad_y = 10'd0; tick();
    ball_x = 10'd25; ball_y = 10'd0; tick();
    check_sb("corner_paddle", S_HOLD, 2'b01);
    tick();
    check_sb("corner_hold", S_HOLD, 2'b01);
    ball_x = 10'd27; tick();
    check_sb("corner_step", S_PLAY, 2'b00);
    tick();
    check_sb("corner_wall", S_HOLD, 2'b10);
    ball_y = 10'd1; tick();
    check_sb("corner_release", S_PLAY, 2'b00);

    // Left player scores to WIN_SCORE
    for (int i = 1; i <= 9; i++) miss_r_round(4'(i), 4'd1, i == 9);
    tick();
    check_sb("over_stay", S_OVER, 2'b11);

    // Restart from OVER; start held during SERVE must not disturb the count
    start = 1'b1; tick();
    check_sb("restart", S_SERVE, 2'b11);
    check("restart_score_l", 32'(score_l), 32'd0);
    check("restart_score_r", 32'(score_r), 32'd0);
    check("restart_game_over", 32'(game_over), 32'd0);
    check("restart_serving", 32'(serving), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_sb("restart_serve_len", S_SERVE, 2'b11);
    tick();
    check_sb("restart_play", S_PLAY, 2'b00);

    // Score once, then reset in the middle of a paddle HOLD
    miss_r_round(4'd1, 4'd0, 1'b0);
    lpad_y = 10'd180; ball_x = 10'd100; tick();
    ball_x = 10'd30; tick();
    check_sb("pre_reset_hit", S_HOLD, 2'b01);
    reset = 1'b1; tick();
    check_sb("hold_reset", S_IDLE, 2'b11);
    check("hold_reset_score_l", 32'(score_l), 32'd0);
    check("hold_reset_score_r", 32'(score_r), 32'd0);
    check("hold_reset_serving", 32'(serving), 32'd1);
    check("hold_reset_game_over", 32'(game_over), 32'd0);
    reset = 1'b0; tick();
    check_sb("post_reset_idle", S_IDLE, 2'b11);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game sequencer for the Pong ball datapath. It watches the ball position and size and both paddle positions, and drives the ball's 2-bit bounce command: 00 none, 01 paddle, 10 wall, 11 recentre/serve. It also keeps the two scores, runs the serve delay and detects game over. It sits between the paddle blocks and the ball block in the GUI top level.

Parameters:
SCREEN_X, 640, horizontal resolution in pixels
SCREEN_Y, 480, vertical resolution in pixels
PAD_W, 10, paddle width in pixels
PAD_H, 60, paddle height in pixels
LPAD_X, 20, left paddle left-edge column
RPAD_X, 610, right paddle left-edge column
SERVE_DELAY, 25000000, number of clock cycles to hold before each serve; counter width 25 bits
WIN_SCORE, 9, score that ends the game; maximum 15

Ports:
clock  in  1  system clock
reset  in  1  reset; synchronous, active-high
start  in  1  level; starts or restarts the game
ball_x  in  10  ball top-left column
ball_y  in  10  ball top-left row
ball_w  in  8  ball width
ball_h  in  8  ball height
lpad_y  in  10  left paddle top row
rpad_y  in  10  right paddle top row
bounce  out  2  command to the ball block
score_l  out  4  left player score
score_r  out  4  right player score
game_over  out  1  high while in the OVER state
serving  out  1  high in IDLE and SERVE

Behaviour:
- Reset values: state=IDLE, bounce=11, scores=0, game_over=0, serving=1, serve counter=0, prev_x/prev_y=ball inputs, dir_r=1, dir_d=1.
- step = (ball_x != prev_x) || (ball_y != prev_y). prev_x/prev_y are registered every cycle.
- Direction tracking: in PLAY and HOLD, whenever step is high:
  - dir_r <= ball_x > prev_x
  - dir_d <= ball_y > prev_y
  - if an axis is unchanged, its direction is held.
- All edge sums are computed in 11 bits, with no wrap-around.
- Events, evaluated combinationally in PLAY on the current inputs:
  - miss_l: !dir_r && ball_x < LPAD_X
  - miss_r: dir_r && ball_x+ball_w > RPAD_X+PAD_W
  - yov(p): ball_y+ball_h > p && ball_y < p+PAD_H
  - hit_l: !dir_r && ball_x <= LPAD_X+PAD_W && ball_x >= LPAD_X && yov(lpad_y)
  - hit_r: dir_r && ball_x+ball_w >= RPAD_X && ball_x+ball_w <= RPAD_X+PAD_W && yov(rpad_y)
  - wall: (!dir_d && ball_y == 0) || (dir_d && ball_y+ball_h >= SCREEN_Y)
  - Priority: miss > hit > wall. If a corner hits both paddle and wall, the paddle bounce is issued first; the wall bounce is issued on re-evaluation after the acknowledge.
- FSM, one registered transition per cycle:
  - IDLE: bounce=11. When start=1, clear scores and go to SERVE.
  - SERVE: bounce=11; the counter increments each cycle. When counter==SERVE_DELAY-1, clear the counter, set dir_r=1 and dir_d=1, and go to PLAY. bounce=00 from the first PLAY cycle.
  - PLAY: bounce=00.
    - miss_l: score_r+1, go to SCORE.
    - miss_r: score_l+1, go to SCORE.
    - hit_l or hit_r: latch code 01, go to HOLD.
    - wall: latch code 10, go to HOLD.
  - HOLD: bounce=latched code until step is seen, then go to PLAY. The ball block samples bounce only on its own move tick, so the code must be held until a move is observed. The step cycle also updates the direction.
  - SCORE: bounce=11 until step is seen (the ball has recentred and moved). Then go to OVER if either score==WIN_SCORE, else SERVE.
  - OVER: bounce=11, game_over=1. When start=1, clear scores and go to SERVE.
- Scores saturate at 15 and never wrap.
- Reset at any cycle, in any state, forces reset values on the next edge. This includes mid-HOLD and mid-SERVE.
- start has no effect in SERVE, PLAY, HOLD or SCORE.
- Latency: event in PLAY to bounce change is 1 cycle.

Test Plan:
- Reset then start=1, SERVE_DELAY=8: bounce=11 for 8 SERVE cycles, then 00. serving falls with the same edge.
- Ball stepping up (dir_d=0) to ball_y=0, ball_x=300: bounce=10 next cycle; holds until ball_y becomes 1; then 00 and dir_d=1.
- dir_r=0, ball_x=30, ball_y=200, lpad_y=180, ball_h=15: bounce=01 until step; the same geometry with lpad_y=300 gives no bounce.
- dir_r=0, ball_x reaches 19: score_r 0→1, bounce=11 until step, then SERVE. With score_l=8 and miss_r: score_l=9 and game_over=1 after the step; start returns to SERVE with scores 0.
- Corner case, wall and left paddle together: bounce=01 first; after the step, 10 if still at the wall.
- Reset asserted during HOLD with bounce=01: next cycle bounce=11, state IDLE, scores 0.
